fifo_frame_reader: RTL and testbench
====================================

Name: fifo_frame_reader

Overview:
Consumer stage that drains the 16-bit sample FIFO through its read-side master interface.
- Polls the FIFO CSR fill level.
- Reads only when a whole frame of FRAME_WORDS words is present.
- Re-emits the words on a valid/ready stream with start/end-of-frame markers, feeding the observer/controller datapath.
- Never issues a read that could underflow, and never emits a partial frame.

Parameters:
FRAME_WORDS, 8, words per frame; legal range 1..255.
POLL_INTERVAL, 16, idle cycles between fill-level polls; legal range 1..65535.
TIMEOUT_CYCLES, 255, waitrequest stall limit; used only with the optional feature.

Ports:
clk_clk  in  1  system clock; all logic is on the rising edge.
reset_reset_n  in  1  asynchronous active-low reset.
enable  in  1  permits new frames to start.
fifo_0_out_read  out  1  FIFO read strobe.
fifo_0_out_waitrequest  in  1  FIFO stall.
fifo_0_out_readdata  in  16  FIFO data; valid in the cycle read=1 and waitrequest=0.
fifo_0_out_csr_address  out  3  CSR address; always 0 (fill_level).
fifo_0_out_csr_read  out  1  CSR read strobe.
fifo_0_out_csr_readdata  in  32  CSR data; valid one cycle after csr_read.
fifo_0_out_csr_write  out  1  tied 0.
fifo_0_out_csr_writedata  out  32  tied 0.
frm_data  out  16  output word.
frm_valid  out  1  output word valid.
frm_ready  in  1  downstream accept.
frm_sop  out  1  first word of frame.
frm_eop  out  1  last word of frame.
busy  out  1  high outside IDLE.
frame_count  out  16  completed frames; wraps at 0xFFFF to 0.
err_timeout  out  1  sticky stall error; 0 without the optional feature.

Behaviour:
- Reset value of every output is 0; state=IDLE; poll timer loads POLL_INTERVAL. Reset mid-frame discards all state; the partial frame is lost and no eop is emitted.
- The handshake is frm_valid & frm_ready. While frm_valid=1, frm_data/sop/eop hold stable until accepted.
- IDLE: the timer decrements only while enable=1. At timer==1, go to POLL.
- POLL: csr_read=1, address=0, for exactly one cycle. Next state is POLL_WAIT.
- POLL_WAIT: capture fill = csr_readdata.
  - If fill >= FRAME_WORDS: go to READ with word index=0.
  - Otherwise: return to IDLE and reload the timer.
  - Compare is unsigned, 32-bit.
- READ:
  - fifo_0_out_read=1 whenever the output register is empty or is being accepted this cycle.
  - A word is taken when read=1 and waitrequest=0. It loads frm_data with frm_valid=1, sop=(index==0), eop=(index==FRAME_WORDS-1); index then increments.
  - read falls in the cycle after the last word is taken; then go to DRAIN.
  - One word per cycle is sustained when frm_ready=1 and waitrequest=0.
- DRAIN: wait for the eop handshake. frame_count increments on that handshake. Then go to POLL immediately if enable=1, else to IDLE with the timer reloaded.
- enable=0 mid-frame: the frame completes fully; enable is sampled only in IDLE and DRAIN.
- FRAME_WORDS=1: sop and eop are both asserted on the same word.
- Simultaneous frm_ready acceptance and a new FIFO word in the same cycle: the register reloads with no bubble.
- fill exactly equal to FRAME_WORDS is sufficient to start READ.

Optional Feature:
FIFO_FRAME_READER_TIMEOUT_EN
- Defined: a stall counter counts consecutive READ cycles with read=1 and waitrequest=1 and clears when a word is taken. When the count reaches TIMEOUT_CYCLES:
  - read drops;
  - if frm_valid=1, the in-flight word is flushed (frm_valid drops); if frm_valid=0, no word is emitted;
  - frame_count does not increment and no eop is emitted;
  - err_timeout sets (cleared only by reset);
  - state goes to IDLE.
- Not defined: no counter; err_timeout is constant 0; READ waits indefinitely.

Test Plan:
- Reset, enable=1, CSR returns fill=8 at first poll, waitrequest=0, frm_ready=1 → csr_read pulses once at cycle 16 after enable. 8 reads on consecutive cycles. sop on word 0, eop on word 7, frame_count=1.
- CSR returns fill=7, then fill=8 at the next poll → no read after the first poll. Second poll follows 16 cycles later. Reading starts after the second poll.
- frm_ready toggles 1,0,0,1 during READ → read is deasserted while the output is held. Data order 0x0001..0x0008 is preserved with no duplication or loss.
- enable drops after word 3 → words 4..7 still emitted with eop. No further csr_read while enable=0. frame_count=1.
- FRAME_WORDS=1, fill=3 → three single-word frames, each with sop=eop=1. A poll precedes each frame. frame_count=3.
- With FIFO_FRAME_READER_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest held 1 from word 2 → read drops after 4 stall cycles. err_timeout=1. No eop. frame_count unchanged. State returns to IDLE.

Source files
------------

// File: rtl/fifo_frame_reader.sv
// Drains whole FRAME_WORDS frames from the sample FIFO onto a valid/ready stream with sop/eop.
// Optional waitrequest stall timeout is compiled in with FIFO_FRAME_READER_TIMEOUT_EN.
module fifo_frame_reader #(
  parameter int unsigned FRAME_WORDS    = 8,
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic        fifo_0_out_read,
  input  logic        fifo_0_out_waitrequest,
  input  logic [15:0] fifo_0_out_readdata,
  output logic [2:0]  fifo_0_out_csr_address,
  output logic        fifo_0_out_csr_read,
  input  logic [31:0] fifo_0_out_csr_readdata,
  output logic        fifo_0_out_csr_write,
  output logic [31:0] fifo_0_out_csr_writedata,
  output logic [15:0] frm_data,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic        frm_sop,
  output logic        frm_eop,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        err_timeout
);

  if (FRAME_WORDS < 1 || FRAME_WORDS > 255 || POLL_INTERVAL < 1 || POLL_INTERVAL > 65535 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fifo_frame_reader: parameter out of legal range");
  end

  typedef enum logic [2:0] {IDLE, POLL, POLL_WAIT, READ, DRAIN} state_t;

  localparam logic [15:0] POLL_LOAD   = 16'(POLL_INTERVAL);
  localparam logic [7:0]  LAST_IDX    = 8'(FRAME_WORDS - 1);
  localparam logic [31:0] FRAME_LEVEL = 32'(FRAME_WORDS);

  state_t      state;
  logic [15:0] timer;
  logic [7:0]  idx;
  logic        take;
  logic        accept;
  logic        stall_hit;

  // Read only when the output register is free this cycle, so a word is never dropped.
  assign fifo_0_out_read          = (state == READ) && (!frm_valid || frm_ready);
  assign take                     = fifo_0_out_read && !fifo_0_out_waitrequest;
  assign accept                   = frm_valid && frm_ready;
  assign fifo_0_out_csr_read      = (state == POLL);
  assign fifo_0_out_csr_address   = '0;
  assign fifo_0_out_csr_write     = 1'b0;
  assign fifo_0_out_csr_writedata = '0;
  assign busy                     = (state != IDLE);

`ifdef FIFO_FRAME_READER_TIMEOUT_EN
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] stall;
  logic        err_q;

  assign stall_hit   = fifo_0_out_read && fifo_0_out_waitrequest &&
                       (stall == STALL_LIMIT - 16'd1);
  assign err_timeout = err_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stall <= '0;
      err_q <= 1'b0;
    end else begin
      if (stall_hit)
        err_q <= 1'b1;
      if (state != READ || take || stall_hit)
        stall <= '0;
      else if (fifo_0_out_read && fifo_0_out_waitrequest)
        stall <= stall + 16'd1;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      timer       <= POLL_LOAD;
      idx         <= '0;
      frm_data    <= '0;
      frm_valid   <= 1'b0;
      frm_sop     <= 1'b0;
      frm_eop     <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (timer == 16'd1) begin
              state <= POLL;
              timer <= POLL_LOAD;
            end else begin
              timer <= timer - 16'd1;
            end
          end
        end
        POLL: state <= POLL_WAIT;
        POLL_WAIT: begin
          if (fifo_0_out_csr_readdata >= FRAME_LEVEL) begin
            state <= READ;
            idx   <= '0;
          end else begin
            state <= IDLE;
            timer <= POLL_LOAD;
          end
        end
        READ: begin
          if (stall_hit) begin
            state     <= IDLE;
            timer     <= POLL_LOAD;
            frm_valid <= 1'b0;
            frm_sop   <= 1'b0;
            frm_eop   <= 1'b0;
          end else if (take) begin
            frm_data  <= fifo_0_out_readdata;
            frm_valid <= 1'b1;
            frm_sop   <= (idx == '0);
            frm_eop   <= (idx == LAST_IDX);
            idx       <= idx + 8'd1;
            if (idx == LAST_IDX)
              state <= DRAIN;
          end else if (accept) begin
            frm_valid <= 1'b0;
          end
        end
        DRAIN: begin
          // Only the eop word can sit in the register here.
          if (accept) begin
            frm_valid   <= 1'b0;
            frm_sop     <= 1'b0;
            frm_eop     <= 1'b0;
            frame_count <= frame_count + 16'd1;
            if (enable) begin
              state <= POLL;
            end else begin
              state <= IDLE;
              timer <= POLL_LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: an 8-word instance with backpressure/enable scenarios
// and a 1-word instance; FIFO_FRAME_READER_TIMEOUT_EN adds the stall-timeout scenario.
module tb_fifo_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, enable1, waitreq, ready;
  logic        read, csr_read, csr_write, read1, csr_read1, csr_write1;
  logic [2:0]  csr_addr, csr_addr1;
  logic [31:0] csr_wdata, csr_wdata1;
  logic [31:0] csr_rdata = '0;
  logic [31:0] csr_rdata1 = '0;
  logic [15:0] rdata, rdata1, frm_data, frm_data1, frame_count, frame_count1;
  logic        frm_valid, frm_sop, frm_eop, busy, err_timeout;
  logic        frm_valid1, frm_sop1, frm_eop1, busy1, err_timeout1;

  int unsigned pushed = 0, popped = 0, pushed1 = 0, popped1 = 0;
  int unsigned checks = 0, errors = 0;

  logic [17:0] words[$];
  logic [17:0] words1[$];
  int unsigned pop_cyc[$];
  int unsigned pp1[$];
  int unsigned cyc = 0, csr_cnt = 0, polls1 = 0, hold_viol = 0, held_cnt = 0, stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_word = '0;

  always #5 clk = ~clk;

  fifo_frame_reader #(.FRAME_WORDS(8), .POLL_INTERVAL(16), .TIMEOUT_CYCLES(4)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
    .fifo_0_out_read(read), .fifo_0_out_waitrequest(waitreq), .fifo_0_out_readdata(rdata),
    .fifo_0_out_csr_address(csr_addr), .fifo_0_out_csr_read(csr_read),
    .fifo_0_out_csr_readdata(csr_rdata), .fifo_0_out_csr_write(csr_write),
    .fifo_0_out_csr_writedata(csr_wdata),
    .frm_data(frm_data), .frm_valid(frm_valid), .frm_ready(ready), .frm_sop(frm_sop),
    .frm_eop(frm_eop), .busy(busy), .frame_count(frame_count), .err_timeout(err_timeout)
  );

  fifo_frame_reader #(.FRAME_WORDS(1), .POLL_INTERVAL(16), .TIMEOUT_CYCLES(4)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable1),
    .fifo_0_out_read(read1), .fifo_0_out_waitrequest(1'b0), .fifo_0_out_readdata(rdata1),
    .fifo_0_out_csr_address(csr_addr1), .fifo_0_out_csr_read(csr_read1),
    .fifo_0_out_csr_readdata(csr_rdata1), .fifo_0_out_csr_write(csr_write1),
    .fifo_0_out_csr_writedata(csr_wdata1),
    .frm_data(frm_data1), .frm_valid(frm_valid1), .frm_ready(1'b1), .frm_sop(frm_sop1),
    .frm_eop(frm_eop1), .busy(busy1), .frame_count(frame_count1), .err_timeout(err_timeout1)
  );

  // FIFO + CSR models: data words count up from 1, fill level = pushed - popped.
  assign rdata  = 16'(popped + 1);
  assign rdata1 = 16'(popped1 + 1);

  always @(posedge clk) begin
    if (csr_read)          csr_rdata  <= 32'(pushed - popped);
    if (read && !waitreq)  popped     <= popped + 1;
    if (csr_read1)         csr_rdata1 <= 32'(pushed1 - popped1);
    if (read1)             popped1    <= popped1 + 1;
  end

  // Monitor samples 1 ns before each rising edge, i.e. the values that edge acts on.
  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (frm_valid && ready)  words.push_back({frm_sop, frm_eop, frm_data});
    if (read && !waitreq)    pop_cyc.push_back(cyc);
    if (read && waitreq)     stall_cnt++;
    if (csr_read)            csr_cnt++;
    if (read && frm_valid && !ready) hold_viol++;
    if (frm_valid && !ready) held_cnt++;
    if (prev_stall && {frm_valid, frm_sop, frm_eop, frm_data} != prev_word) hold_viol++;
    prev_stall = frm_valid && !ready;
    prev_word  = {frm_valid, frm_sop, frm_eop, frm_data};
    if (frm_valid1) words1.push_back({frm_sop1, frm_eop1, frm_data1});
    if (read1) begin
      pp1.push_back(polls1);
      polls1 = 0;
    end else if (csr_read1) begin
      polls1++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int unsigned base, input int unsigned first);
    check({tag, "_len"}, 32'(words.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      if (base + i < words.size())
        check($sformatf("%s_w%0d", tag, i), 32'(words[base + i]),
              32'({i == 0, i == 7, 16'(first + i)}));
  endtask

  task automatic wait_frames(input logic [15:0] target);
    int unsigned n = 0;
    while (frame_count != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("frame_count_%0d", target), 32'(frame_count), 32'(target));
  endtask

  task automatic wait_poll();
    int unsigned n = 0;
    while (!csr_read && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("poll_seen", 32'(csr_read), 32'd1);
  endtask

  initial begin
    int unsigned n, base, p0, c0, lowcnt, k;
    logic [3:0] pat;
    rst_n = 1'b0; enable = 1'b0; enable1 = 1'b0; ready = 1'b1; waitreq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({read, csr_read, frm_valid, frm_sop, frm_eop, busy, err_timeout, csr_write}), 32'd0);
    check("rst_data", 32'(frm_data), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_csr_wdata", csr_wdata, 32'd0);
    check("rst_csr_addr", 32'(csr_addr), 32'd0);
    rst_n = 1'b1;
    pushed = 8;
    @(negedge clk);

    // Full frame with fill=8: first poll 16 cycles after enable, 8 back-to-back reads.
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!csr_read && n < 100);
    check("poll_latency", n, 32'd16);
    wait_frames(16'd1);
    check_frame("t1", 0, 1);
    if (pop_cyc.size() >= 8)
      check("t1_burst", pop_cyc[7] - pop_cyc[0], 32'd7);
    else
      check("t1_pops", pop_cyc.size(), 32'd8);

    // fill=7 is rejected; the next poll comes after 16 idle cycles and sees fill=8.
    pushed += 7;
    wait_poll();
    @(negedge clk);
    p0 = popped;
    pushed += 1;
    lowcnt = 0;
    n = 0;
    while (!csr_read && n < 100) begin
      @(negedge clk);
      if (!busy) lowcnt++;
      n++;
    end
    check("t2_idle_gap", lowcnt, 32'd16);
    check("t2_no_read", popped, p0);
    wait_frames(16'd2);
    check_frame("t2", 8, 9);

    // Backpressure pattern 1,0,0,1 on frm_ready.
    pushed += 8;
    pat = 4'b1001;
    k = 0;
    n = 0;
    while (frame_count != 16'd3 && n < 400) begin
      @(negedge clk);
      ready = pat[k % 4];
      k++;
      n++;
    end
    ready = 1'b1;
    check("frame_count_3", 32'(frame_count), 32'd3);
    check_frame("t3", 16, 17);
    check("t3_hold_viol", hold_viol, 32'd0);
    check("t3_held_seen", 32'(held_cnt > 0), 32'd1);

    // enable drops after word 3: frame still completes, then no more polls.
    pushed += 8;
    base = words.size();
    n = 0;
    while (words.size() < base + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    wait_frames(16'd4);
    check_frame("t4", 24, 25);
    c0 = csr_cnt;
    repeat (40) @(negedge clk);
    check("t4_no_poll", csr_cnt, c0);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_count_hold", 32'(frame_count), 32'd4);

    // FRAME_WORDS=1 instance with fill=3: three sop+eop frames, each after its own poll.
    pushed1 = 3;
    enable1 = 1'b1;
    n = 0;
    while (frame_count1 != 16'd3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_frames", 32'(frame_count1), 32'd3);
    check("t5_len", words1.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < words1.size())
        check($sformatf("t5_w%0d", i), 32'(words1[i]), 32'({2'b11, 16'(i + 1)}));
    for (int i = 0; i < 3; i++)
      if (i < pp1.size())
        check($sformatf("t5_polls%0d", i), pp1[i], 32'd1);

`ifdef FIFO_FRAME_READER_TIMEOUT_EN
    // Waitrequest stuck from word 2: 4 stall cycles, then abort to IDLE with err_timeout.
    base = words.size();
    p0 = popped;
    c0 = stall_cnt;
    pushed += 8;
    enable = 1'b1;
    n = 0;
    while (!err_timeout && n < 300) begin
      @(negedge clk);
      if (popped - p0 >= 2) waitreq = 1'b1;
      n++;
    end
    check("t6_err", 32'(err_timeout), 32'd1);
    check("t6_stalls", stall_cnt - c0, 32'd4);
    check("t6_read_low", 32'(read), 32'd0);
    check("t6_valid_low", 32'(frm_valid), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_count", 32'(frame_count), 32'd4);
    check("t6_words", words.size() - base, 32'd2);
    for (int i = 0; i < 2; i++)
      if (base + i < words.size())
        check($sformatf("t6_no_eop%0d", i), 32'(words[base + i][16]), 32'd0);
`else
    check("err_timeout_off", 32'(err_timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
